// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_pkg
// Description : Shared definitions for the SDRAM client-side test master.
//               Client address field widths (bank/row/col), data width and
//               the one-hot state encoding of the test-master FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    localparam int unsigned BANK_ADDR_WIDTH  = 2;
    localparam int unsigned ROW_WIDTH        = 13;
    localparam int unsigned COL_WIDTH        = 9;
    localparam int unsigned SDRAM_DATA_WIDTH = 16;
    // Client address is {bank, row, col}
    localparam int unsigned SDRAM_ADDR_WIDTH = BANK_ADDR_WIDTH + ROW_WIDTH + COL_WIDTH;

    localparam int unsigned STATE_WIDTH = 7;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE    = 7'b000_0001,
        ST_WR_REQ  = 7'b000_0010,
        ST_WR_GAP  = 7'b000_0100,
        ST_RD_REQ  = 7'b000_1000,
        ST_RD_WAIT = 7'b001_0000,
        ST_RD_GAP  = 7'b010_0000,
        ST_DONE    = 7'b100_0000
    } tm_state_t;

endpackage
`default_nettype wire

// File: rtl/sdram_test_checker.sv
`default_nettype none
// ============================================================================
// Module      : sdram_test_checker
// Description : Read-data comparator for the SDRAM test master. Counts
//               miscompares (saturating) and latches the address of the
//               first one.
// Ports       : clk, reset_l (sync, active-low), clear (start of a run),
//               cur_addr / exp_data / rd_data / rd_valid (compare inputs),
//               err_cnt, first_err_addr (results).
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_test_checker #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_l,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_valid,
    output logic [15:0]           err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    logic w_miscompare;

    assign w_miscompare = rd_valid && (rd_data != exp_data);

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            err_cnt        <= 16'h0000;
            first_err_addr <= '0;
        end else if (clear) begin
            err_cnt        <= 16'h0000;
            first_err_addr <= '0;
        end else if (w_miscompare) begin
            if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'h0001;
            end
            // Only the very first miscompare of a run records its address
            if (err_cnt == 16'h0000) begin
                first_err_addr <= cur_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_test_master.sv
`default_nettype none
// ============================================================================
// Module      : sdram_test_master
// Description : Self-checking SDRAM memory test initiator. Phase A writes
//               addr^PATTERN_XOR over the window and reads it back; phase B
//               repeats with the inverted pattern. Handshake waits are
//               bounded by TIMEOUT_CYCLES.
// Ports       : clk, reset_l (sync, active-low), start (pulse);
//               status: busy, done, pass, err_cnt, first_err_addr,
//               timeout_err;
//               controller: sdram_req/ack/addr/rh_wl/data_w/data_r/data_r_en.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_test_master #(
    parameter int unsigned          ADDR_WIDTH     = sdram_pkg::SDRAM_ADDR_WIDTH,
    parameter int unsigned          DATA_WIDTH     = sdram_pkg::SDRAM_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR    = '0,
    parameter int unsigned          TEST_WORDS     = 1024,
    parameter logic [DATA_WIDTH-1:0] PATTERN_XOR   = 16'hA5C3,
    parameter int unsigned          TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  reset_l,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  timeout_err,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic                  sdram_rh_wl,
    output logic [DATA_WIDTH-1:0] sdram_data_w,
    input  logic [DATA_WIDTH-1:0] sdram_data_r,
    input  logic                  sdram_data_r_en
);

    import sdram_pkg::*;

    // Window end, modulo 2^ADDR_WIDTH so the window may wrap through zero
    localparam logic [ADDR_WIDTH-1:0] c_last_addr  = START_ADDR + ADDR_WIDTH'(TEST_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one   = ADDR_WIDTH'(1);
    localparam int unsigned           c_timer_width = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_timer_width-1:0] c_timer_last = c_timer_width'(TIMEOUT_CYCLES - 1);
    localparam logic [c_timer_width-1:0] c_timer_one  = c_timer_width'(1);

    function automatic logic [DATA_WIDTH-1:0] exp_of(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic                  inv);
        logic [DATA_WIDTH-1:0] v;
        v = a[DATA_WIDTH-1:0] ^ PATTERN_XOR;
        return inv ? ~v : v;
    endfunction

    tm_state_t                r_state;
    logic [ADDR_WIDTH-1:0]    r_cur;
    logic                     r_phase_b;
    logic [c_timer_width-1:0] r_timer;

    logic                  w_start_ok;
    logic                  w_at_last;
    logic [ADDR_WIDTH-1:0] w_cur_next;
    logic [DATA_WIDTH-1:0] w_exp;
    logic                  w_rd_valid;
    logic                  w_waiting;
    logic                  w_progress;
    logic                  w_timeout;

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_at_last  = (r_cur == c_last_addr);
    assign w_cur_next = r_cur + c_addr_one;
    assign w_exp      = exp_of(r_cur, r_phase_b);
    assign w_rd_valid = (r_state == ST_RD_WAIT) && sdram_data_r_en;

    // Handshake progress wins over an expiring timer in the same cycle
    assign w_waiting  = (r_state == ST_WR_REQ) || (r_state == ST_RD_REQ) || (r_state == ST_RD_WAIT);
    assign w_progress = (r_state == ST_RD_WAIT) ? sdram_data_r_en : sdram_ack;
    assign w_timeout  = w_waiting && !w_progress && (r_timer == c_timer_last);

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_state      <= ST_IDLE;
            r_cur        <= '0;
            r_phase_b    <= 1'b0;
            r_timer      <= '0;
            sdram_req    <= 1'b0;
            sdram_addr   <= '0;
            sdram_rh_wl  <= 1'b1;
            sdram_data_w <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout_err  <= 1'b0;
        end else if (w_timeout) begin
            timeout_err <= 1'b1;
            sdram_req   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= 1'b0;
            r_timer     <= '0;
            r_state     <= ST_DONE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        timeout_err  <= 1'b0;
                        busy         <= 1'b1;
                        r_cur        <= START_ADDR;
                        r_phase_b    <= 1'b0;
                        r_timer      <= '0;
                        sdram_req    <= 1'b1;
                        sdram_rh_wl  <= 1'b0;
                        sdram_addr   <= START_ADDR;
                        sdram_data_w <= exp_of(START_ADDR, 1'b0);
                        r_state      <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        r_timer   <= '0;
                        r_state   <= ST_WR_GAP;
                    end else begin
                        r_timer <= r_timer + c_timer_one;
                    end
                end
                ST_WR_GAP: begin
                    sdram_req <= 1'b1;
                    if (w_at_last) begin
                        r_cur       <= START_ADDR;
                        sdram_rh_wl <= 1'b1;
                        sdram_addr  <= START_ADDR;
                        r_state     <= ST_RD_REQ;
                    end else begin
                        r_cur        <= w_cur_next;
                        sdram_rh_wl  <= 1'b0;
                        sdram_addr   <= w_cur_next;
                        sdram_data_w <= exp_of(w_cur_next, r_phase_b);
                        r_state      <= ST_WR_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        r_timer   <= '0;
                        r_state   <= ST_RD_WAIT;
                    end else begin
                        r_timer <= r_timer + c_timer_one;
                    end
                end
                ST_RD_WAIT: begin
                    if (sdram_data_r_en) begin
                        r_timer <= '0;
                        r_state <= ST_RD_GAP;
                    end else begin
                        r_timer <= r_timer + c_timer_one;
                    end
                end
                ST_RD_GAP: begin
                    if (w_at_last && r_phase_b) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        // err_cnt already reflects the last compare here
                        pass    <= (err_cnt == 16'h0000);
                        r_state <= ST_DONE;
                    end else if (w_at_last) begin
                        r_phase_b    <= 1'b1;
                        r_cur        <= START_ADDR;
                        sdram_req    <= 1'b1;
                        sdram_rh_wl  <= 1'b0;
                        sdram_addr   <= START_ADDR;
                        sdram_data_w <= exp_of(START_ADDR, 1'b1);
                        r_state      <= ST_WR_REQ;
                    end else begin
                        r_cur       <= w_cur_next;
                        sdram_req   <= 1'b1;
                        sdram_rh_wl <= 1'b1;
                        sdram_addr  <= w_cur_next;
                        r_state     <= ST_RD_REQ;
                    end
                end
                default: begin
                    sdram_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    sdram_test_checker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_checker (
        .clk            (clk),
        .reset_l        (reset_l),
        .clear          (w_start_ok),
        .cur_addr       (r_cur),
        .exp_data       (w_exp),
        .rd_data        (sdram_data_r),
        .rd_valid       (w_rd_valid),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

endmodule
`default_nettype wire

// File: tb/tb_sdram_test_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sdram_test_master
// Description : Bench for sdram_test_master. Two instances (window at 0 and a
//               window wrapping past all-ones) driven by a controller model
//               with adjustable ack / read-data latency and fault modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_test_master;

    localparam int          N      = 4;
    localparam logic [23:0] START0 = 24'h000000;
    localparam logic [23:0] START1 = 24'hFFFFFE;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        reset_l;
    logic        start_s[2];
    logic        busy_s[2], done_s[2], pass_s[2], tmo_s[2];
    logic        req_s[2], ack_s[2], rh_wl_s[2], rden_s[2];
    logic [15:0] err_s[2], data_w_s[2], data_r_s[2];
    logic [23:0] ferr_s[2], addr_s[2];

    sdram_test_master #(
        .ADDR_WIDTH(24), .DATA_WIDTH(16), .START_ADDR(START0), .TEST_WORDS(N),
        .PATTERN_XOR(16'hA5C3), .TIMEOUT_CYCLES(15)
    ) dut0 (
        .clk(clk), .reset_l(reset_l), .start(start_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .pass(pass_s[0]), .err_cnt(err_s[0]),
        .first_err_addr(ferr_s[0]), .timeout_err(tmo_s[0]), .sdram_req(req_s[0]),
        .sdram_ack(ack_s[0]), .sdram_addr(addr_s[0]), .sdram_rh_wl(rh_wl_s[0]),
        .sdram_data_w(data_w_s[0]), .sdram_data_r(data_r_s[0]),
        .sdram_data_r_en(rden_s[0])
    );

    sdram_test_master #(
        .ADDR_WIDTH(24), .DATA_WIDTH(16), .START_ADDR(START1), .TEST_WORDS(N),
        .PATTERN_XOR(16'hA5C3), .TIMEOUT_CYCLES(15)
    ) dut1 (
        .clk(clk), .reset_l(reset_l), .start(start_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .pass(pass_s[1]), .err_cnt(err_s[1]),
        .first_err_addr(ferr_s[1]), .timeout_err(tmo_s[1]), .sdram_req(req_s[1]),
        .sdram_ack(ack_s[1]), .sdram_addr(addr_s[1]), .sdram_rh_wl(rh_wl_s[1]),
        .sdram_data_w(data_w_s[1]), .sdram_data_r(data_r_s[1]),
        .sdram_data_r_en(rden_s[1])
    );

    // ---------------- controller model controls (written by stimulus) -------
    int   ack_lat[2], rd_lat[2], corrupt_idx[2];
    logic no_ack[2], no_rden[2], spur_arm[2];

    // ---------------- controller model state --------------------------------
    int          cnt[2], rd_cnt[2], rd_idx[2];
    logic        rd_pend[2], rd_bad[2], prev_ack[2];
    logic [23:0] rd_addr[2];
    int          gap_viol[2]   = '{0, 0};
    int          order_viol[2] = '{0, 0};
    logic [15:0] mem [logic [24:0]];
    logic        log_rw[2][1024];
    logic [23:0] log_a[2][1024];
    logic [15:0] log_d[2][1024];
    int          log_n[2] = '{0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [24:0] key;
            // Protocol monitors on the pre-edge values of the cycle just ended
            if (prev_ack[k] && req_s[k]) gap_viol[k]++;
            if (req_s[k] && rh_wl_s[k] && !ack_s[k] && rd_pend[k]) order_viol[k]++;
            prev_ack[k] = ack_s[k];
            ack_s[k]  <= 1'b0;
            rden_s[k] <= 1'b0;
            if (!reset_l) begin
                cnt[k]     = 0;
                rd_pend[k] = 1'b0;
                rd_idx[k]  = 0;
                prev_ack[k] = 1'b0;
            end else begin
                if (!busy_s[k]) begin
                    rd_pend[k] = 1'b0;
                    rd_idx[k]  = 0;
                end
                if (rd_pend[k] && !no_rden[k]) begin
                    if (rd_cnt[k] <= 1) begin
                        key = {k[0], rd_addr[k]};
                        rden_s[k]   <= 1'b1;
                        data_r_s[k] <= rd_bad[k] ? 16'h0000
                                     : (mem.exists(key) ? mem[key] : 16'h0000);
                        rd_pend[k] = 1'b0;
                    end else begin
                        rd_cnt[k]--;
                    end
                end
                if (req_s[k] && !ack_s[k]) begin
                    if (spur_arm[k] && !rh_wl_s[k] && cnt[k] == 0) begin
                        rden_s[k]   <= 1'b1;
                        data_r_s[k] <= 16'h0000;
                    end
                    if (!no_ack[k]) begin
                        if (cnt[k] >= ack_lat[k] - 1) begin
                            ack_s[k] <= 1'b1;
                            cnt[k] = 0;
                            if (log_n[k] < 1024) begin
                                log_rw[k][log_n[k]] = rh_wl_s[k];
                                log_a[k][log_n[k]]  = addr_s[k];
                                log_d[k][log_n[k]]  = data_w_s[k];
                                log_n[k]++;
                            end
                            if (rh_wl_s[k]) begin
                                rd_pend[k] = 1'b1;
                                rd_cnt[k]  = rd_lat[k];
                                rd_addr[k] = addr_s[k];
                                rd_bad[k]  = (rd_idx[k] == corrupt_idx[k]);
                                rd_idx[k]++;
                            end else begin
                                mem[{k[0], addr_s[k]}] = data_w_s[k];
                            end
                        end else begin
                            cnt[k]++;
                        end
                    end
                end else if (!req_s[k]) begin
                    cnt[k] = 0;
                end
            end
        end
    end

    // ---------------- checking helpers --------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected write data for an address in a given phase
    function automatic logic [15:0] model_data(input logic [23:0] a, input logic inv);
        logic [15:0] v;
        v = a[15:0] ^ 16'hA5C3;
        return inv ? ~v : v;
    endfunction

    task automatic pulse_start(input int k);
        @(negedge clk);
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
    endtask

    // Waits for done with a cycle budget; optionally pokes start while busy
    task automatic wait_done(input int k, input string tag, input bit poke);
        int n;
        n = 0;
        while (!done_s[k] && n < 3000) begin
            start_s[k] = poke && (n % 40 == 20);
            @(negedge clk);
            n++;
        end
        start_s[k] = 1'b0;
        check({tag, "_finished"}, 64'(done_s[k]), 64'd1);
    endtask

    // Compares logged transactions of one run with the expected sequence
    task automatic check_log(input int k, input int base, input logic [23:0] s, input string tag);
        int got;
        got = log_n[k] - base;
        check({tag, "_txn_count"}, 64'(got), 64'(4 * N));
        for (int j = 0; j < 4 * N && j < got; j++) begin
            logic        ph, rd;
            int          i;
            logic [23:0] a;
            logic [40:0] expv, obs;
            ph   = (j >= 2 * N);
            rd   = ((j % (2 * N)) >= N);
            i    = j % N;
            a    = s + 24'(i);
            expv = {rd, a, rd ? 16'h0000 : model_data(a, ph)};
            obs  = {log_rw[k][base + j], log_a[k][base + j],
                    rd ? 16'h0000 : log_d[k][base + j]};
            check({tag, "_txn"}, 64'(obs), 64'(expv));
        end
    endtask

    task automatic run_and_check(input int k, input logic [23:0] s, input int corrupt,
                                 input bit poke, input string tag);
        int          base;
        logic [15:0] exp_err;
        logic [23:0] exp_first;
        logic [23:0] ca;
        corrupt_idx[k] = corrupt;
        base = log_n[k];
        exp_err   = 16'h0000;
        exp_first = 24'h000000;
        if (corrupt >= 0 && corrupt < 2 * N) begin
            ca = s + 24'(corrupt % N);
            if (model_data(ca, corrupt >= N) != 16'h0000) begin
                exp_err   = 16'h0001;
                exp_first = ca;
            end
        end
        pulse_start(k);
        check({tag, "_busy"}, 64'(busy_s[k]), 64'd1);
        wait_done(k, tag, poke);
        check({tag, "_err_cnt"}, 64'(err_s[k]), 64'(exp_err));
        check({tag, "_first_err"}, 64'(ferr_s[k]), 64'(exp_first));
        check({tag, "_pass"}, 64'(pass_s[k]), 64'(exp_err == 16'h0000));
        check({tag, "_timeout"}, 64'(tmo_s[k]), 64'd0);
        check({tag, "_busy_end"}, 64'(busy_s[k]), 64'd0);
        check_log(k, base, s, tag);
        check({tag, "_gap_rule"}, 64'(gap_viol[k]), 64'd0);
        check({tag, "_rd_order"}, 64'(order_viol[k]), 64'd0);
        corrupt_idx[k] = -1;
    endtask

    // ---------------- directed sequence -------------------------------------
    initial begin
        int hi, n, base;
        reset_l = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0;  ack_lat[k] = 3;    rd_lat[k] = 4;
            no_ack[k] = 1'b0;   no_rden[k] = 1'b0; spur_arm[k] = 1'b0;
            corrupt_idx[k] = -1;
        end
        repeat (3) @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_ctl", 64'({req_s[0], rh_wl_s[0], busy_s[0], done_s[0], pass_s[0], tmo_s[0]}),
              64'(6'b010000));
        check("rst_addr", 64'(addr_s[0]), 64'd0);
        check("rst_data_w", 64'(data_w_s[0]), 64'd0);
        check("rst_err_cnt", 64'(err_s[0]), 64'd0);
        check("rst_first_err", 64'(ferr_s[0]), 64'd0);

        // Baseline run, fixed latencies 3/4
        run_and_check(0, START0, -1, 1'b0, "basic");
        // Read at address 2 in phase A returns zero
        run_and_check(0, START0, 2, 1'b0, "corrupt");

        // Controller never acks: req held exactly TIMEOUT_CYCLES cycles
        no_ack[0] = 1'b1;
        pulse_start(0);
        hi = req_s[0] ? 1 : 0;
        n  = 0;
        while (!done_s[0] && n < 200) begin
            @(negedge clk);
            if (req_s[0]) hi++;
            n++;
        end
        check("noack_req_cycles", 64'(hi), 64'd15);
        check("noack_timeout", 64'(tmo_s[0]), 64'd1);
        check("noack_done_pass", 64'({done_s[0], pass_s[0], busy_s[0], req_s[0]}), 64'(4'b1000));
        no_ack[0] = 1'b0;

        // Acks but no read data: times out in the first read wait
        no_rden[0] = 1'b1;
        base = log_n[0];
        pulse_start(0);
        wait_done(0, "nordn", 1'b0);
        check("nordn_timeout", 64'(tmo_s[0]), 64'd1);
        check("nordn_err_cnt", 64'(err_s[0]), 64'd0);
        check("nordn_pass", 64'(pass_s[0]), 64'd0);
        check("nordn_txns", 64'(log_n[0] - base), 64'(N + 1));
        no_rden[0] = 1'b0;

        // Start pokes while busy plus spurious read strobes during writes
        spur_arm[0] = 1'b1;
        run_and_check(0, START0, -1, 1'b1, "spurious");
        spur_arm[0] = 1'b0;

        // One-cycle reset in the middle of a write request
        pulse_start(0);
        n = 0;
        while (!(req_s[0] && !rh_wl_s[0] && addr_s[0] == 24'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reached_write", 64'(req_s[0] && !rh_wl_s[0]), 64'd1);
        reset_l = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;
        check("midrst_state", 64'({req_s[0], busy_s[0], done_s[0]}), 64'd0);
        check("midrst_err_cnt", 64'(err_s[0]), 64'd0);
        run_and_check(0, START0, -1, 1'b0, "after_rst");

        // Randomised latencies and fault location
        for (int r = 0; r < 4; r++) begin
            int c;
            ack_lat[0] = int'($urandom_range(1, 5));
            rd_lat[0]  = int'($urandom_range(1, 6));
            c = int'($urandom_range(0, 8));
            run_and_check(0, START0, (c == 8) ? -1 : c, 1'b0, "random");
        end

        // Window wrapping past all-ones
        ack_lat[1] = int'($urandom_range(1, 5));
        rd_lat[1]  = int'($urandom_range(1, 6));
        run_and_check(1, START1, -1, 1'b0, "wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
